// File: rtl/lockin_mixer_accum.sv
// Square-wave lock-in: per-channel +/-1 mixing of a shared sample, integrate-and-dump over 2^PER_LOG2 periods.
// Latency: last window sample on in_data -> out_valid 2 cycles later; windows run back to back.
// Backpressure: none on input; unaccepted result is overwritten by the next dump and flags sticky overrun.
// Optional LOCKIN_MIXER_INVERT_EN adds invert_in to flip each channel's latched reference sign.
module lockin_mixer_accum #(
    parameter int IN_W     = 12,
    parameter int CNT_W    = 5,
    parameter int NUM_CH   = 2,
    parameter int PER_LOG2 = 1,
    localparam int OUT_W   = IN_W + 1 + CNT_W + 1 + PER_LOG2
) (
    input  logic                      clk64,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      sign_in,
    input  logic [CNT_W-1:0]          counter_in,
    input  logic [NUM_CH*CNT_W-1:0]   phase_in,
`ifdef LOCKIN_MIXER_INVERT_EN
    input  logic [NUM_CH-1:0]         invert_in,
`endif
    output logic [NUM_CH*OUT_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    localparam int SCNT_W = CNT_W + 1 + PER_LOG2;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t                   state;
    logic [SCNT_W-1:0]        scnt;
    logic [NUM_CH-1:0]        sign_reg;
    logic [CNT_W-1:0]         phase_reg [NUM_CH];
    logic signed [IN_W:0]     mix [NUM_CH];
    logic                     mix_vld;
    logic signed [OUT_W-1:0]  acc [NUM_CH];
    logic signed [OUT_W-1:0]  sum [NUM_CH];
    logic [NUM_CH-1:0]        inv;
    logic signed [IN_W:0]     din_ext;
    logic                     dump;
    logic                     accept;

`ifdef LOCKIN_MIXER_INVERT_EN
    assign inv = invert_in;
`else
    assign inv = '0;
`endif

    assign din_ext = $signed({in_data[IN_W-1], in_data});
    assign dump    = (state == RUN) && mix_vld && (scnt == '1);
    assign accept  = out_valid && out_ready;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sum[ch] = acc[ch] + {{(OUT_W-IN_W-1){mix[ch][IN_W]}}, mix[ch]};
        end
    end

    always_ff @(posedge clk64 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= ARM;
                ARM:     if (!enable) state <= IDLE;
                         else if (counter_in == '0) state <= RUN;
                RUN:     if (!enable) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk64 or negedge reset_n) begin
        if (!reset_n) begin
            sign_reg  <= '1;
            mix_vld   <= 1'b0;
            scnt      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                phase_reg[ch] <= '0;
                mix[ch]       <= '0;
                acc[ch]       <= '0;
            end
        end else begin
            mix_vld <= (state == RUN);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (counter_in == phase_reg[ch])
                    sign_reg[ch] <= sign_in ^ inv[ch];
                mix[ch] <= sign_reg[ch] ? din_ext : -din_ext;
                // Phases only move at window edges so every window sees one reference alignment.
                if (state == ARM || dump)
                    phase_reg[ch] <= phase_in[ch*CNT_W +: CNT_W];
                if (state != RUN)
                    acc[ch] <= '0;
                else if (mix_vld)
                    acc[ch] <= dump ? '0 : sum[ch];
                if (dump)
                    out_data[ch*OUT_W +: OUT_W] <= sum[ch];
            end

            if (state != RUN)
                scnt <= '0;
            else if (mix_vld)
                scnt <= scnt + 1'b1;

            if (dump)
                out_valid <= 1'b1;
            else if (accept)
                out_valid <= 1'b0;

            if (dump && out_valid && !out_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lockin_mixer_accum.sv
// Scoreboarded bench for lockin_mixer_accum: directed windows, expected sums queued at issue time.
module tb_lockin_mixer_accum;

    localparam int IN_W   = 12;
    localparam int CNT_W  = 5;
    localparam int NUM_CH = 2;
    localparam int OUT_W  = 20;

    logic                     clk64 = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     enable = 1'b0;
    logic [IN_W-1:0]          in_data = '0;
    logic                     sign_in = 1'b1;
    logic [CNT_W-1:0]         counter_in = '0;
    logic [NUM_CH*CNT_W-1:0]  phase_in = {5'd16, 5'd0};
    logic [NUM_CH*OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic                     overrun;
    logic                     overrun_clr = 1'b0;
`ifdef LOCKIN_MIXER_INVERT_EN
    logic [NUM_CH-1:0]        invert_in = '0;
`endif

    lockin_mixer_accum dut (
        .clk64       (clk64),
        .reset_n     (reset_n),
        .enable      (enable),
        .in_data     (in_data),
        .sign_in     (sign_in),
        .counter_in  (counter_in),
        .phase_in    (phase_in),
`ifdef LOCKIN_MIXER_INVERT_EN
        .invert_in   (invert_in),
`endif
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk64 = ~clk64;

    typedef struct {
        int ch0;
        int ch1;
    } exp_t;

    exp_t  expq[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    sign_toggle = 1'b0;
    logic  sign_const  = 1'b1;
    logic signed [IN_W-1:0] win_data [4];

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ch_val(input int ch);
        logic signed [OUT_W-1:0] v;
        v = out_data[ch*OUT_W +: OUT_W];
        return int'(v);
    endfunction

    task automatic push_exp(input int e0, input int e1);
        exp_t e;
        e.ch0 = e0;
        e.ch1 = e1;
        expq.push_back(e);
    endtask

    // Counter and oscillator sign advance together; sign flips on each counter wrap in toggle mode.
    task automatic tick();
        @(posedge clk64);
        #1;
        cyc++;
        counter_in = CNT_W'(cyc);
        sign_in    = sign_toggle ? cyc[5] : sign_const;
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 64; i++) begin
            tick();
            if (int'(counter_in) == v) break;
        end
    endtask

    task automatic run(input int nwin);
        wait_cnt(5);
        enable = 1'b1;
        wait_cnt(0);
        for (int w = 0; w < nwin; w++) begin
            for (int j = 0; j < 128; j++) begin
                tick();
                if (j == 0) in_data = win_data[w];
            end
        end
        repeat (3) tick();
        enable = 1'b0;
        repeat (4) tick();
    endtask

    always @(negedge clk64) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got ch0=%0d ch1=%0d, expected no result", ch_val(0), ch_val(1));
            end else begin
                e = expq.pop_front();
                chk("result_ch0", ch_val(0), e.ch0);
                chk("result_ch1", ch_val(1), e.ch1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data_zero", int'(out_data == '0), 1);
        chk("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Constant positive reference, mid-range sample.
        sign_const = 1'b1;
        push_exp(12800, 12800);
        win_data[0] = 12'sd100;
        run(1);

        // Negated reference on the most negative sample.
        sign_const = 1'b0;
        repeat (40) tick();
        push_exp(262144, 262144);
        win_data[0] = -12'sd2048;
        run(1);

        // Reference toggling every half period: constant input integrates to zero.
        sign_toggle = 1'b1;
        push_exp(0, 0);
        win_data[0] = 12'sd100;
        run(1);
        sign_toggle = 1'b0;

        // Two back-to-back windows at the full-scale extremes.
        sign_const = 1'b1;
        repeat (40) tick();
        push_exp(-262144, -262144);
        push_exp(262016, 262016);
        win_data[0] = -12'sd2048;
        win_data[1] = 12'sd2047;
        run(2);

        // Held result gets overwritten by the next window.
        out_ready = 1'b0;
        push_exp(6400, 6400);
        win_data[0] = 12'sd100;
        win_data[1] = 12'sd50;
        run(2);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_valid_held", int'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("valid_cleared_after_accept", int'(out_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Pending result is dropped by an asynchronous reset.
        out_ready = 1'b0;
        win_data[0] = 12'sd10;
        run(1);
        chk("pending_valid", int'(out_valid), 1);
        chk("pending_ch0", ch_val(0), 1280);
        chk("single_dump_no_ovr", int'(overrun), 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_data_zero", int'(out_data == '0), 1);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();

        // Abort after 60 samples, then a fresh full window.
        wait_cnt(5);
        enable = 1'b1;
        wait_cnt(0);
        for (int j = 0; j < 60; j++) begin
            tick();
            if (j == 0) in_data = 12'sd77;
        end
        enable = 1'b0;
        repeat (5) tick();
        chk("abort_no_valid", int'(out_valid), 0);
        push_exp(12800, 12800);
        win_data[0] = 12'sd100;
        run(1);

`ifdef LOCKIN_MIXER_INVERT_EN
        invert_in = 2'b10;
        push_exp(12800, -12800);
        win_data[0] = 12'sd100;
        run(1);
        invert_in = 2'b00;
`endif

        for (int i = 0; i < 500 && expq.size() != 0; i++) tick();
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
